// File: rtl/out_commit_unit_pkg.sv
// Shared types and default sizing for the OUT-commit unit and its UART transmitter.
package out_commit_unit_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // 100 MHz clock, 115200 baud
    localparam int OUT_CLK_PER_BIT = 868;
    // Pending (speculative) FIFO holds 2**OUT_PEND_W bytes
    localparam int OUT_PEND_W      = 3;
    // Committed TX FIFO holds 2**OUT_TXQ_W bytes
    localparam int OUT_TXQ_W       = 4;

endpackage

// File: rtl/out_commit_unit_if.sv
// Commit-ring OUT handshake: the ring drives valid, the responder drives ready.
interface out_commit_unit_if;
    logic valid;
    logic ready;

    modport master (output valid, input ready);
    modport slave  (input valid, output ready);
endinterface

// File: rtl/out_commit_unit_uart_tx.sv
// UART 8N1 transmitter: pulls one byte per frame through an in_valid/in_ready
// handshake and shifts it out LSB first. Defining UART_TX_STOP2_EN stretches
// the stop bit to two bit times.
module uart_tx
    import out_commit_unit_pkg::*;
#(
    parameter int CLK_PER_BIT = OUT_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       txd,
    output logic       busy
);

`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif
    localparam int TMR_W = $clog2(STOP_BITS * CLK_PER_BIT + 1);
    localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLK_PER_BIT - 1);
    localparam logic [TMR_W-1:0] STOP_LOAD = TMR_W'(STOP_BITS * CLK_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             txd_q, txd_d;

    // Frame sequencing; txd is computed from the next state so the line is registered
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        data_d   = data_q;
        in_ready = (state_q == TX_IDLE);
        case (state_q)
            TX_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    timer_d = BIT_LOAD;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (timer_q == '0) begin
                    state_d = TX_DATA;
                    idx_d   = 3'd0;
                    timer_d = BIT_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (timer_q == '0) begin
                    if (idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        timer_d = STOP_LOAD;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        timer_d = BIT_LOAD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (timer_q == '0) begin
                    state_d = TX_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = data_d[idx_d];
            default:  txd_d = 1'b1;
        endcase
    end

    // State register; reset aborts any frame and returns the line to mark
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            timer_q <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != TX_IDLE);

endmodule

// File: rtl/out_commit_unit.sv
// OUT-commit responder: buffers speculative OUT bytes, moves one byte per
// accepted commit into the TX FIFO, drops uncommitted bytes on flush and
// sends committed bytes over UART. UART_TX_STOP2_EN selects two stop bits.
module out_commit_unit
    import out_commit_unit_pkg::*;
#(
    parameter int PEND_W      = OUT_PEND_W,
    parameter int TXQ_W       = OUT_TXQ_W,
    parameter int CLK_PER_BIT = OUT_CLK_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exec_valid,
    output logic              exec_ready,
    input  logic [7:0]        exec_data,
    input  logic              flush,
    out_commit_unit_if.slave  commit_req_out,
    output logic              txd,
    output logic              tx_busy
);

    logic [7:0] pend_mem [2**PEND_W];
    logic [7:0] txq_mem  [2**TXQ_W];

    logic [PEND_W:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [TXQ_W:0]  txq_wr_q, txq_wr_d, txq_rd_q, txq_rd_d;

    logic pend_empty, pend_full, txq_empty, txq_full;
    logic pend_push, commit_hs, txq_pop;
    logic tx_in_ready, tx_fsm_busy;

    assign pend_empty = (pend_wr_q == pend_rd_q);
    assign pend_full  = (pend_wr_q[PEND_W] != pend_rd_q[PEND_W]) &&
                        (pend_wr_q[PEND_W-1:0] == pend_rd_q[PEND_W-1:0]);
    assign txq_empty  = (txq_wr_q == txq_rd_q);
    assign txq_full   = (txq_wr_q[TXQ_W] != txq_rd_q[TXQ_W]) &&
                        (txq_wr_q[TXQ_W-1:0] == txq_rd_q[TXQ_W-1:0]);

    // A full pending FIFO refuses a push even when a commit frees a slot this cycle
    assign exec_ready           = !pend_full;
    assign pend_push            = exec_valid && exec_ready && !flush;
    assign commit_req_out.ready = !pend_empty && !txq_full;
    assign commit_hs            = commit_req_out.valid && commit_req_out.ready;
    assign txq_pop              = !txq_empty && tx_in_ready;

    // Pointer updates; flush collapses the pending FIFO onto its post-commit read pointer
    always_comb begin
        pend_rd_d = pend_rd_q + (PEND_W+1)'(commit_hs);
        pend_wr_d = pend_wr_q + (PEND_W+1)'(pend_push);
        if (flush) begin
            pend_wr_d = pend_rd_d;
        end
        txq_wr_d = txq_wr_q + (TXQ_W+1)'(commit_hs);
        txq_rd_d = txq_rd_q + (TXQ_W+1)'(txq_pop);
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_wr_q <= '0;
            pend_rd_q <= '0;
            txq_wr_q  <= '0;
            txq_rd_q  <= '0;
        end else begin
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            txq_wr_q  <= txq_wr_d;
            txq_rd_q  <= txq_rd_d;
        end
    end

    // FIFO storage; a commit copies the pending head straight into the TX FIFO
    always_ff @(posedge clk) begin
        if (pend_push) begin
            pend_mem[pend_wr_q[PEND_W-1:0]] <= exec_data;
        end
        if (commit_hs) begin
            txq_mem[txq_wr_q[TXQ_W-1:0]] <= pend_mem[pend_rd_q[PEND_W-1:0]];
        end
    end

    uart_tx #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .in_valid (!txq_empty),
        .in_ready (tx_in_ready),
        .in_data  (txq_mem[txq_rd_q[TXQ_W-1:0]]),
        .txd      (txd),
        .busy     (tx_fsm_busy)
    );

    assign tx_busy = tx_fsm_busy || !txq_empty;

endmodule

// File: tb/tb_out_commit_unit.sv
// Scoreboard bench for out_commit_unit: a queue-level model predicts the
// handshake outputs each cycle and the start cycle and payload of each UART
// frame; a separate monitor decodes txd and checks frames against the queue.
module tb_out_commit_unit;

    localparam int CPB = 4;
`ifdef UART_TX_STOP2_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       exec_valid;
    logic       exec_ready;
    logic [7:0] exec_data;
    logic       flush;
    logic       txd;
    logic       tx_busy;

    out_commit_unit_if cif();

    out_commit_unit #(
        .PEND_W      (3),
        .TXQ_W       (4),
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .exec_valid     (exec_valid),
        .exec_ready     (exec_ready),
        .exec_data      (exec_data),
        .flush          (flush),
        .commit_req_out (cif),
        .txd            (txd),
        .tx_busy        (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         idle_at = 0;
    bit         mon_abort = 1'b0;
    logic [7:0] pend[$];
    logic [7:0] txq[$];
    frame_t     sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model
    task automatic step(input bit ev, input logic [7:0] ed, input bit cv, input bit fl);
        bit     exp_er, exp_cr, exp_busy, hs, push;
        frame_t f;
        exp_er   = (pend.size() < 8);
        exp_cr   = (pend.size() > 0) && (txq.size() < 16);
        exp_busy = (cyc < idle_at) || (txq.size() > 0);
        chk("exec_ready", 32'(exec_ready), 32'(exp_er));
        chk("commit_ready", 32'(cif.ready), 32'(exp_cr));
        chk("tx_busy", 32'(tx_busy), 32'(exp_busy));
        exec_valid = ev;
        exec_data  = ed;
        cif.valid  = cv;
        flush      = fl;
        hs   = cv && exp_cr;
        push = ev && exp_er && !fl;
        if (cyc >= idle_at && txq.size() > 0) begin
            f.data  = txq.pop_front();
            f.start = cyc + 1;
            sb.push_back(f);
            idle_at = cyc + 1 + FRAME;
        end
        if (hs) txq.push_back(pend.pop_front());
        if (fl) pend.delete();
        if (push) pend.push_back(ed);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend.size() > 0 || txq.size() > 0 || cyc < idle_at + 2) && n < 5000) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n++;
        end
        chk("drain_bounded", 32'(n < 5000), 32'd1);
    endtask

    // Monitor: decode UART frames at mid-bit and compare with the scoreboard
    initial begin : monitor
        logic       prev;
        logic       start_bit, stop_bit, have;
        logic [7:0] got;
        int         s, nframes;
        frame_t     f;
        prev    = 1'b1;
        nframes = 0;
        forever begin
            @(posedge clk);
            #2;
            if (prev === 1'b1 && txd === 1'b0) begin
                s    = cyc;
                have = (sb.size() > 0);
                f.data  = 8'h00;
                f.start = -1;
                if (have) f = sb.pop_front();
                for (int i = 0; i < CPB / 2; i++) begin
                    @(posedge clk);
                    #2;
                end
                start_bit = txd;
                for (int k = 0; k < 8; k++) begin
                    for (int i = 0; i < CPB; i++) begin
                        @(posedge clk);
                        #2;
                    end
                    got[k] = txd;
                end
                for (int i = 0; i < CPB; i++) begin
                    @(posedge clk);
                    #2;
                end
                stop_bit = txd;
                if (!mon_abort) begin
                    chk("frame_expected", 32'(have), 32'd1);
                    chk("frame_start_cycle", 32'(s), 32'(f.start));
                    chk("frame_start_bit", 32'(start_bit), 32'd0);
                    chk("frame_data", 32'(got), 32'(f.data));
                    chk("frame_stop_bit", 32'(stop_bit), 32'd1);
                    $display("frame %0d: data 0x%02h start cycle %0d", nframes, got, s);
                    nframes++;
                end
                prev = stop_bit;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin : driver
        bit         ev, cv, fl;
        logic [7:0] ed;
        int         lows, cprob;
        reset      = 1'b1;
        exec_valid = 1'b0;
        exec_data  = 8'h00;
        cif.valid  = 1'b0;
        flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_tx_busy", 32'(tx_busy), 32'd0);
        chk("reset_exec_ready", 32'(exec_ready), 32'd1);
        chk("reset_commit_ready", 32'(cif.ready), 32'd0);

        // Single byte with commit one cycle after the push
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        drain();

        // Backpressure: nine pushes with no commits, then hold commit valid
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        drain();

        // Flush after one of three bytes committed, then a fresh byte
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Flush in the same cycle as a commit handshake
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        drain();

        // Fill the TX FIFO behind a frame in flight
        for (int i = 0; i < 80; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        drain();

        // Randomized traffic with varying commit pressure
        for (int i = 0; i < 3000; i++) begin
            cprob = ((i / 400) % 2 == 0) ? 85 : 15;
            ev = ($urandom_range(0, 99) < 70);
            ed = 8'($urandom);
            cv = ($urandom_range(0, 99) < cprob);
            fl = ($urandom_range(0, 99) < 3);
            step(ev, ed, cv, fl);
        end
        drain();

        // Reset in the middle of the data bits
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3 * CPB + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        mon_abort = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        chk("midframe_reset_txd", 32'(txd), 32'd1);
        chk("midframe_reset_tx_busy", 32'(tx_busy), 32'd0);
        pend.delete();
        txq.delete();
        idle_at = 0;
        lows = 0;
        for (int i = 0; i < 12 * CPB; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (txd !== 1'b1) lows++;
        end
        chk("post_reset_line_quiet", 32'(lows), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
